// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants: default widths, reset PC, bubble instruction and PC stride.
package fetch_pkg;

  localparam int          ADDR_W_DEF    = 32;
  localparam int          DATA_W_DEF    = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0
  localparam int          PC_INCR       = 4;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction memory port, IF/ID register out.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              stall;
  logic              flush;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rd;
  logic [DATA_W-1:0] if_id_instr;
  logic [ADDR_W-1:0] if_id_pc;
  logic [ADDR_W-1:0] if_id_pc4;
  logic              if_id_valid;
  logic              misalign;
  logic [31:0]       fetch_count;

  modport master (
    input  stall, flush, branch_taken, branch_target, imem_rd,
    output imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid, misalign, fetch_count
  );

  modport slave (
    output stall, flush, branch_taken, branch_target, imem_rd,
    input  imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid, misalign, fetch_count
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; priority reset > bubble > stall > capture. Bubble keeps pc/pc4 stable.
module if_id_reg #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble,
  input  logic              stall,
  input  logic [DATA_W-1:0] instr_d,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [ADDR_W-1:0] pc4_d,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc4,
  output logic              valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= NOP_INSTR;
      pc    <= '0;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (!stall) begin
      instr <= instr_d;
      pc    <= pc_d;
      pc4   <= pc4_d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and loads the IF/ID register.
// Redirect beats stall; only imem_addr is combinational (straight from the PC).
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] target_aligned;
  logic              bubble;
  logic              capture;
  logic              misalign;
  logic [31:0]       fetch_count;

  assign pc_seq         = pc + ADDR_W'(PC_INCR);
  assign target_aligned = {bus.branch_target[ADDR_W-1:2], 2'b00};
  assign bubble         = bus.flush | bus.branch_taken;
  assign capture        = ~bubble & ~bus.stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      misalign    <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (bus.branch_taken) begin
        pc <= target_aligned;
      end else if (!bus.stall) begin
        pc <= pc_seq;
      end
      // Status only: the fetch itself always goes to the word-aligned target.
      misalign <= bus.branch_taken & (|bus.branch_target[1:0]);
      if (capture) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.misalign    = misalign;
  assign bus.fetch_count = fetch_count;

  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_pc4;
  logic              id_valid;

  if_id_reg #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .bubble  (bubble),
    .stall   (bus.stall),
    .instr_d (bus.imem_rd),
    .pc_d    (pc),
    .pc4_d   (pc_seq),
    .instr   (id_instr),
    .pc      (id_pc),
    .pc4     (id_pc4),
    .valid   (id_valid)
  );

  assign bus.if_id_instr = id_instr;
  assign bus.if_id_pc    = id_pc;
  assign bus.if_id_pc4   = id_pc4;
  assign bus.if_id_valid = id_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: driver pushes model-predicted post-edge state, monitor pops and compares after each edge.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instruction_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign bus.imem_rd = mem_word(bus.imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic        val;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        driving_done = 1'b0;

  // Reference state, advanced once per clock edge from the fetch rules.
  logic [31:0] m_pc = 32'h0, m_instr = NOP, m_ipc = 0, m_ipc4 = 0, m_cnt = 0;
  logic        m_val = 1'b0, m_mis = 1'b0;

  task automatic step(input logic rst, input logic st, input logic fl,
                      input logic br, input logic [31:0] tgt);
    exp_t e;
    @(negedge clk);
    reset             = rst;
    bus.stall         = st;
    bus.flush         = fl;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    if (rst) begin
      m_pc = 32'h0; m_instr = NOP; m_ipc = 0; m_ipc4 = 0; m_val = 0; m_mis = 0; m_cnt = 0;
    end else begin
      if (br || fl) begin
        m_instr = NOP;
        m_val   = 1'b0;
      end else if (!st) begin
        m_instr = mem_word(m_pc);
        m_ipc   = m_pc;
        m_ipc4  = m_pc + 32'd4;
        m_val   = 1'b1;
        m_cnt   = m_cnt + 32'd1;
      end
      m_mis = br && (tgt % 4 != 0);
      if (br)       m_pc = tgt - (tgt % 4);
      else if (!st) m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.ipc4 = m_ipc4;
    e.val = m_val; e.mis = m_mis; e.cnt = m_cnt;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("imem_addr",   bus.imem_addr,          e.pc);
        chk("if_id_instr", bus.if_id_instr,        e.instr);
        chk("if_id_pc",    bus.if_id_pc,           e.ipc);
        chk("if_id_pc4",   bus.if_id_pc4,          e.ipc4);
        chk("if_id_valid", {31'b0, bus.if_id_valid}, {31'b0, e.val});
        chk("misalign",    {31'b0, bus.misalign},  {31'b0, e.mis});
        chk("fetch_count", bus.fetch_count,        e.cnt);
      end
    end
  end

  initial begin : driver
    logic [31:0] tgt;
    reset = 1'b1;
    bus.stall = 0; bus.flush = 0; bus.branch_taken = 0; bus.branch_target = 0;

    // Reset, then free-running fetch from address 0.
    repeat (3) step(1, 0, 0, 0, 32'h0);
    repeat (3) step(0, 0, 0, 0, 32'h0);
    // PC now 12; redirect to 8 and stall there for two cycles.
    step(0, 0, 0, 1, 32'h8);
    step(0, 0, 0, 0, 32'h0);
    repeat (2) step(0, 1, 0, 0, 32'h0);
    repeat (2) step(0, 0, 0, 0, 32'h0);
    // Branch to 0x40 from 0x10.
    step(0, 0, 0, 1, 32'h10);
    step(0, 0, 0, 1, 32'h40);
    repeat (2) step(0, 0, 0, 0, 32'h0);
    // Branch with stall, aligned and misaligned targets.
    step(0, 1, 0, 1, 32'h20);
    step(0, 0, 0, 0, 32'h0);
    step(0, 1, 0, 1, 32'h22);
    repeat (2) step(0, 0, 0, 0, 32'h0);
    // Flush with stall, no branch.
    step(0, 1, 1, 0, 32'h0);
    step(0, 0, 1, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    // Address wrap at the top of memory.
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    repeat (3) step(0, 0, 0, 0, 32'h0);
    // Reset mid-stream with stall and flush asserted.
    step(1, 1, 1, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 1023));
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           tgt);
    end
    step(0, 0, 0, 0, 32'h0);

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    driving_done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
